// File: rtl/axi_dmem_slave.sv
// -----------------------------------------------------------------------------
// axi_dmem_slave
//   AXI4-Lite slave data memory that sits behind the core's load/store master.
//   It takes byte-strobed word writes and word reads and always answers OKAY.
//   Storage is a synchronous word-organised RAM of 2^(AXI_AWIDTH-2) words.
//   The write and read paths are independent FSMs. Each path allows one
//   outstanding transaction.
//
// Ports
//   CLK, RST             clock (rising edge); synchronous active-high reset
//   AXI_AW*              write address channel (byte address, low 2 bits ignored)
//   AXI_W*               write data channel (lane-aligned data + byte strobes)
//   AXI_B*               write response channel (BRESP always OKAY)
//   AXI_AR*              read address channel (byte address, low 2 bits ignored)
//   AXI_R*               read data channel (full aligned word, RRESP always OKAY)
// -----------------------------------------------------------------------------
module axi_dmem_slave #(
  parameter int AXI_AWIDTH = 12,
  parameter int AXI_DWIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
  input  logic                    AXI_AWVALID,
  output logic                    AXI_AWREADY,
  input  logic [AXI_DWIDTH-1:0]   AXI_WDATA,
  input  logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
  input  logic                    AXI_WVALID,
  output logic                    AXI_WREADY,
  output logic [1:0]              AXI_BRESP,
  output logic                    AXI_BVALID,
  input  logic                    AXI_BREADY,
  input  logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
  input  logic                    AXI_ARVALID,
  output logic                    AXI_ARREADY,
  output logic [AXI_DWIDTH-1:0]   AXI_RDATA,
  output logic [1:0]              AXI_RRESP,
  output logic                    AXI_RVALID,
  input  logic                    AXI_RREADY
);

  localparam int IDX_W  = AXI_AWIDTH - 2;
  localparam int DEPTH  = 1 << IDX_W;
  localparam int NBYTES = AXI_DWIDTH / 8;

  typedef enum logic { W_IDLE, W_RESP } w_state_e;
  typedef enum logic { R_IDLE, R_DATA } r_state_e;

  // The master places data and strobes in the correct lanes, so the byte
  // offset bits carry no information here.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, AXI_AWADDR[1:0], AXI_ARADDR[1:0]};

  logic [AXI_DWIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  w_state_e              w_state, w_state_nxt;
  logic                  aw_got, w_got;
  logic [IDX_W-1:0]      aw_idx;
  logic [AXI_DWIDTH-1:0] w_data;
  logic [NBYTES-1:0]     w_strb;
  logic                  aw_hs, w_hs, w_commit;

  // AW and W are accepted independently while idle. Each READY drops once
  // its beat is held and stays low until the response has been taken.
  assign AXI_AWREADY = (w_state == W_IDLE) && !aw_got;
  assign AXI_WREADY  = (w_state == W_IDLE) && !w_got;
  assign aw_hs       = AXI_AWVALID && AXI_AWREADY;
  assign w_hs        = AXI_WVALID  && AXI_WREADY;
  assign w_commit    = (w_state == W_IDLE) && aw_got && w_got;

  assign AXI_BVALID  = (w_state == W_RESP);
  assign AXI_BRESP   = 2'b00;

  always_ff @(posedge CLK) begin
    if (RST) begin
      w_state <= W_IDLE;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments, so every
      // process sees the values from before this edge. That is also how the
      // read port gets the old word when it collides with a commit.
      w_state <= w_state_nxt;
      if (aw_hs) begin
        aw_got <= 1'b1;
        aw_idx <= AXI_AWADDR[AXI_AWIDTH-1:2];
      end
      if (w_hs) begin
        w_got  <= 1'b1;
        w_data <= AXI_WDATA;
        w_strb <= AXI_WSTRB;
      end
      if (w_commit) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
    end
  end

  always_comb begin
    // NOTE: assigning a default first means every path through the block
    // drives the signal, so no latch is inferred.
    w_state_nxt = w_state;
    unique case (w_state)
      W_IDLE: if (w_commit)   w_state_nxt = W_RESP;
      W_RESP: if (AXI_BREADY) w_state_nxt = W_IDLE;
      default:                w_state_nxt = W_IDLE;
    endcase
  end

  // NOTE: the RAM array has no reset. Its contents survive RST, and leaving
  // out the reset lets the array map onto a plain block RAM. A commit that
  // lands on a reset edge is dropped along with the rest of the transaction.
  always_ff @(posedge CLK) begin
    if (w_commit && !RST) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (w_strb[i]) mem[aw_idx][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  r_state_e              r_state, r_state_nxt;
  logic [AXI_DWIDTH-1:0] rdata_q;
  logic                  ar_hs;

  assign AXI_ARREADY = (r_state == R_IDLE);
  assign ar_hs       = AXI_ARVALID && AXI_ARREADY;
  assign AXI_RVALID  = (r_state == R_DATA);
  assign AXI_RDATA   = rdata_q;
  assign AXI_RRESP   = 2'b00;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= R_IDLE;
      rdata_q <= '0;
    end else begin
      r_state <= r_state_nxt;
      // RDATA is loaded only on capture, so it holds through backpressure
      // and keeps its last value after the handshake.
      if (ar_hs) rdata_q <= mem[AXI_ARADDR[AXI_AWIDTH-1:2]];
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    unique case (r_state)
      R_IDLE: if (AXI_ARVALID) r_state_nxt = R_DATA;
      R_DATA: if (AXI_RREADY)  r_state_nxt = R_IDLE;
      default:                 r_state_nxt = R_IDLE;
    endcase
  end

endmodule

// File: doc/axi_dmem_slave.md
Name: axi_dmem_slave

Overview:
- AXI4-Lite slave data memory directly downstream of the core's load/store master stage.
- Accepts byte-strobed word writes and word reads and returns OKAY responses.
- Holds a synchronous word-organised RAM.
- Independent write and read FSMs; one outstanding transaction per direction.

Parameters:
AXI_AWIDTH, 12, byte address width; RAM depth = 2^(AXI_AWIDTH-2) words
AXI_DWIDTH, 32, data width; fixed at 32, other values unsupported

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  reset
AXI_AWADDR  in  AXI_AWIDTH  write byte address
AXI_AWVALID  in  1  write address valid
AXI_AWREADY  out  1  write address accepted
AXI_WDATA  in  32  write data, lane-aligned
AXI_WSTRB  in  4  byte enables, bit i -> WDATA[8i+7:8i]
AXI_WVALID  in  1  write data valid
AXI_WREADY  out  1  write data accepted
AXI_BRESP  out  2  write response, always 2'b00
AXI_BVALID  out  1  write response valid
AXI_BREADY  in  1  master accepts response
AXI_ARADDR  in  AXI_AWIDTH  read byte address
AXI_ARVALID  in  1  read address valid
AXI_ARREADY  out  1  read address accepted
AXI_RDATA  out  32  full aligned read word
AXI_RRESP  out  2  read response, always 2'b00
AXI_RVALID  out  1  read data valid
AXI_RREADY  in  1  master accepts read data

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset:
  - Sampled on CLK edge while RST=1.
  - AWREADY=1, WREADY=1, ARREADY=1.
  - BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0.
  - All latches cleared; both FSMs to IDLE.
  - RAM contents not cleared.
  - Reset mid-transaction aborts it; a pending write that has not committed is dropped.
- Addressing: word index = ADDR[AXI_AWIDTH-1:2]. ADDR[1:0] ignored; the master places data/strobes in lanes. No out-of-range case exists.
- Write FSM states: W_IDLE, W_RESP.
  - In W_IDLE, AW and W channels handshake independently, in either order or in the same cycle.
  - AW handshake (AWVALID&AWREADY) latches the address; AWREADY drops to 0 until the response completes.
  - W handshake latches WDATA and WSTRB; WREADY drops to 0 likewise.
  - Once both are latched, the RAM is written in the next cycle: only bytes with strobe=1 change.
  - In that same cycle BVALID is set to 1 and the FSM goes to W_RESP.
  - W_RESP: BVALID held until BREADY=1. On that edge BVALID=0, AWREADY=WREADY=1, FSM returns to W_IDLE.
  - If BREADY is already 1 when BVALID rises, the response completes on the next edge.
  - WSTRB=0: no bytes change; a normal OKAY response is still issued.
  - Minimum write latency, both handshakes in cycle N: RAM updated and BVALID=1 at edge N+1.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. An AR handshake at edge N reads RAM[index] into RDATA, sets RVALID=1 and moves to R_DATA, with ARREADY=0.
  - Read latency is 1 cycle.
  - R_DATA: RDATA/RVALID held stable until RREADY=1. On that edge RVALID=0, ARREADY=1, back to R_IDLE.
  - RDATA keeps its last value after the handshake.
- Simultaneous events:
  - Read and write are fully concurrent.
  - If the read capture and the write commit target the same word on the same edge, the read returns the old word (read-before-write).
  - A read captured on a later edge sees the new data.
- No response other than OKAY is generated.
- Protocol assumption: the master holds VALID and payload until READY. Payload changes while VALID=1 and READY=0 are not required to be handled.

Test Plan:
- Reset, then full-word write:
  - RST=1 for 2 cycles -> AWREADY=WREADY=ARREADY=1, BVALID=RVALID=0.
  - AWADDR=0x010 and WDATA=0xDEADBEEF with WSTRB=4'hF in the same cycle -> BVALID=1 one cycle later, BRESP=00.
  - Read 0x010 -> RDATA=0xDEADBEEF, RVALID one cycle after the AR handshake.
- Byte and halfword strobes:
  - Word 0x020 holds 0x11223344.
  - Write WDATA=0x0000AA00, WSTRB=4'b0010 -> word becomes 0x1122AA44.
  - Write WDATA=0xBBCC0000, WSTRB=4'b1100 -> word becomes 0xBBCCAA44.
  - Write with WSTRB=0 -> unchanged, BRESP=00.
- Channel ordering:
  - W handshake 3 cycles before AW -> WREADY=0 after its handshake; write commits one cycle after AW.
  - Reverse order behaves symmetrically.
- Backpressure:
  - BREADY=0 for 5 cycles -> BVALID held; AWREADY=WREADY=0 throughout.
  - RREADY=0 for 4 cycles -> RDATA/RVALID stable; ARREADY=0.
- Concurrency: read of word 0x030 (old 0x0) captured on the same edge as a write commit of 0x55555555 to 0x030 -> RDATA=0x0; an immediate re-read returns 0x55555555.
- Reset mid-operation: AW latched, W not yet sent, RST=1 -> all READY=1, no RAM change, no BVALID afterwards.
